// File: rtl/ledscan_ctrl.sv
// ---------------------------------------------------------------------------
// ledscan_ctrl
//   Time-multiplexed scanner for common-anode 7-seg / LED digit banks.
//   NDIG digits share one segment bus. Each digit owns a slot of 16 sub-ticks.
//   One sub-tick lasts DIV clocks. The first BLANK sub-ticks of every slot are
//   dark, which stops ghosting between neighbouring digits. After the gap,
//   brightness is a 16-level PWM count of lit sub-ticks. A digit can also be
//   blinked, using one bit of a free-running frame counter.
//
// Ports
//   clock          in   1          system clock
//   rst            in   1          asynchronous, active-low reset
//   en             in   NDIG       per-digit enable (1 = digit may light)
//   display        in   NDIG*SEGW  packed [NDIG-1:0][SEGW-1:0] segment patterns
//   blink          in   NDIG       per-digit blink request
//   bright         in   4          brightness, 0 = dark, 15 = max
//   targeten       out  NDIG       digit selects, active-low (1 = off)
//   targetdisplay  out  SEGW       segment pattern of the digit being scanned
//   frame_start    out  1          1-cycle pulse when the scan wraps to digit 0
//
// All outputs are registered from the current state. They therefore trail a
// state change by one clock. en, blink and bright are sampled live every cycle.
// ---------------------------------------------------------------------------
module ledscan_ctrl #(
  parameter int NDIG       = 8,
  parameter int SEGW       = 8,
  parameter int DIV        = 1000,
  parameter int BLANK      = 1,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NDIG-1:0]        en,
  input  logic [NDIG*SEGW-1:0]   display,
  input  logic [NDIG-1:0]        blink,
  input  logic [3:0]             bright,
  output logic [NDIG-1:0]        targeten,
  output logic [SEGW-1:0]        targetdisplay,
  output logic                   frame_start
);

  localparam int PCW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SELW = $clog2(NDIG);

  localparam logic [PCW-1:0]  PC_LAST  = PCW'(DIV - 1);
  localparam logic [SELW-1:0] SEL_LAST = SELW'(NDIG - 1);
  localparam logic [4:0]      BLANK5   = 5'(BLANK);
  localparam logic [4:0]      MAX_LIT  = 5'(16 - BLANK);

  // State
  logic [PCW-1:0]        pc;
  logic [3:0]            sub;
  logic [SELW-1:0]       sel;
  logic [BLINK_LOG2-1:0] frame;
  logic [SEGW-1:0]       shadow;

  logic [NDIG-1:0][SEGW-1:0] disp_a;
  assign disp_a = display;

  // Timing events
  logic            tick;
  logic            slot_end;
  logic            wrap;
  logic [SELW-1:0] sel_next;

  assign tick     = (pc == PC_LAST);
  assign slot_end = tick && (sub == 4'd15);
  // sel is compared against NDIG-1 explicitly. A non-power-of-2 NDIG then
  // never lets sel run into the unused codes.
  assign wrap     = slot_end && (sel == SEL_LAST);
  assign sel_next = (sel == SEL_LAST) ? '0 : sel + SELW'(1);

  // Lit decision, taken from the registered state and the live inputs
  logic [4:0] bright_eff;
  logic [4:0] sub_off;
  logic       lit;

  always_comb begin
    bright_eff = ({1'b0, bright} < MAX_LIT) ? {1'b0, bright} : MAX_LIT;
    sub_off    = {1'b0, sub} - BLANK5;
    // The subtraction may wrap during the blank gap. The sub >= BLANK term
    // masks that case.
    lit        = en[sel]
                 && ({1'b0, sub} >= BLANK5)
                 && (sub_off < bright_eff)
                 && !(blink[sel] && frame[BLINK_LOG2-1]);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pc            <= '0;
      sub           <= '0;
      sel           <= '0;
      frame         <= '0;
      shadow        <= '0;
      targeten      <= '1;
      targetdisplay <= '0;
      frame_start   <= 1'b0;
    end else begin
      pc <= tick ? '0 : pc + PCW'(1);

      if (tick) begin
        sub <= sub + 4'd1;
      end

      if (slot_end) begin
        sel    <= sel_next;
        // Latch the pattern for the slot that is about to start. Writes to
        // display during a slot then cannot tear the digit being shown.
        shadow <= disp_a[sel_next];
      end

      if (wrap) begin
        frame <= frame + BLINK_LOG2'(1);
      end

      targeten      <= lit ? ~(NDIG'(1) << sel) : '1;
      targetdisplay <= shadow;
      frame_start   <= wrap;
    end
  end

endmodule

// File: tb/tb_ledscan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ledscan_ctrl
//   Drives two scanners, NDIG=4 and NDIG=5, from the same stimulus. The
//   reference model derives every digit's state from a count of cycles since
//   reset release, using plain arithmetic. On each rising edge it pushes the
//   expected registered outputs into a queue. A monitor on the falling edge
//   pops each entry and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_ledscan_ctrl;

  localparam int SEGW       = 8;
  localparam int DIV        = 2;
  localparam int BLANK      = 1;
  localparam int BLINK_LOG2 = 1;
  localparam int SLOT       = 16 * DIV;
  localparam int W          = 14;   // {frame_start, display[7:0], selects[4:0]}

  localparam logic [W-1:0] RST_EXP = {1'b0, 8'h00, 5'h1F};

  // Clock / reset
  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  // Shared stimulus
  logic [4:0]        en;
  logic [4:0]        blink;
  logic [3:0]        bright;
  logic [5*SEGW-1:0] display;

  // DUT outputs
  logic [3:0] te4;
  logic [7:0] td4;
  logic       fs4;
  logic [4:0] te5;
  logic [7:0] td5;
  logic       fs5;

  ledscan_ctrl #(
    .NDIG(4), .SEGW(SEGW), .DIV(DIV), .BLANK(BLANK), .BLINK_LOG2(BLINK_LOG2)
  ) dut4 (
    .clock         (clock),
    .rst           (rst),
    .en            (en[3:0]),
    .display       (display[4*SEGW-1:0]),
    .blink         (blink[3:0]),
    .bright        (bright),
    .targeten      (te4),
    .targetdisplay (td4),
    .frame_start   (fs4)
  );

  ledscan_ctrl #(
    .NDIG(5), .SEGW(SEGW), .DIV(DIV), .BLANK(BLANK), .BLINK_LOG2(BLINK_LOG2)
  ) dut5 (
    .clock         (clock),
    .rst           (rst),
    .en            (en),
    .display       (display),
    .blink         (blink),
    .bright        (bright),
    .targeten      (te5),
    .targetdisplay (td5),
    .frame_start   (fs5)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q4[$];
  logic [W-1:0] exp_q5[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model
  longint     n = 0;       // cycles since reset release, i.e. the state index
  logic [7:0] sh4 = 8'h00; // pattern being shown in the current slot
  logic [7:0] sh5 = 8'h00;

  function automatic logic [W-1:0] model_out(input int nd, input longint cyc, input logic [7:0] sh);
    int sub, sel, frame, be;
    logic lit, fs, blink_phase;
    logic [4:0] sel_v;
    sub   = int'((cyc / DIV) % 16);
    sel   = int'((cyc / SLOT) % nd);
    frame = int'((cyc / (SLOT * nd)) % (1 << BLINK_LOG2));
    be    = (int'(bright) < 16 - BLANK) ? int'(bright) : 16 - BLANK;
    blink_phase = ((frame >> (BLINK_LOG2 - 1)) & 1) == 1;
    lit   = en[sel] && (sub >= BLANK) && ((sub - BLANK) < be) && !(blink[sel] && blink_phase);
    sel_v = lit ? ~(5'b00001 << sel) : 5'h1F;
    fs    = (cyc % (SLOT * nd)) == longint'(SLOT * nd - 1);
    return {fs, sh, sel_v};
  endfunction

  function automatic logic [7:0] next_shadow(input int nd, input longint cyc);
    int s;
    s = int'(((cyc + 1) / SLOT) % nd);
    return display[s*SEGW +: SEGW];
  endfunction

  always @(posedge clock) begin
    if (!rst) begin
      exp_q4.push_back(RST_EXP);
      exp_q5.push_back(RST_EXP);
      n   = 0;
      sh4 = 8'h00;
      sh5 = 8'h00;
    end else begin
      exp_q4.push_back(model_out(4, n, sh4));
      exp_q5.push_back(model_out(5, n, sh5));
      if ((n % SLOT) == longint'(SLOT - 1)) begin
        sh4 = next_shadow(4, n);
        sh5 = next_shadow(5, n);
      end
      n++;
    end
  end

  // Monitor
  int cyc    = 0;
  int last4  = -1;
  int last5  = -1;

  always @(negedge clock) begin
    logic [W-1:0] e;
    cyc++;
    if (exp_q4.size() == 0) begin
      check("scb4_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q4.pop_front();
      check("scb4", 32'({fs4, td4, 1'b1, te4}), 32'(e));
    end
    if (exp_q5.size() == 0) begin
      check("scb5_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q5.pop_front();
      check("scb5", 32'({fs5, td5, te5}), 32'(e));
    end
    check("one_sel4", 32'($countones(~te4) <= 1), 32'd1);
    check("one_sel5", 32'($countones(~te5) <= 1), 32'd1);

    // Frame period, measured directly from frame_start pulses
    if (!rst) begin
      last4 = -1;
      last5 = -1;
    end else begin
      if (fs4) begin
        if (last4 >= 0) check("frame_period4", 32'(cyc - last4), 32'(SLOT * 4));
        last4 = cyc;
      end
      if (fs5) begin
        if (last5 >= 0) check("frame_period5", 32'(cyc - last5), 32'(SLOT * 5));
        last5 = cyc;
      end
    end
  end

  // Driver
  task automatic run(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_te4"}, 32'(te4), 32'h0000000F);
    check({tag, "_td4"}, 32'(td4), 32'd0);
    check({tag, "_fs4"}, 32'(fs4), 32'd0);
    check({tag, "_te5"}, 32'(te5), 32'h0000001F);
    check({tag, "_td5"}, 32'(td5), 32'd0);
    check({tag, "_fs5"}, 32'(fs5), 32'd0);
  endtask

  initial begin
    en      = 5'h1F;
    blink   = 5'h00;
    bright  = 4'd15;
    display = {8'h55, 8'h11, 8'h22, 8'h33, 8'h44};

    // Reset hold
    run(3);
    check_reset_outputs("rst_hold");
    rst = 1'b1;

    // Full brightness, all digits enabled
    run(400);

    // Brightness sweep, including both ends
    bright = 4'd0;  run(200);
    bright = 4'd4;  run(200);
    bright = 4'd15; run(100);

    // Sparse enables
    en = 5'b00101;  run(340);
    en = 5'h1F;

    // Blink on digit 1, frames alternate dark / lit
    blink = 5'b00010; run(700);
    blink = 5'h00;

    // Digit 2 pattern rewritten at arbitrary points inside slots
    repeat (20) begin
      run($urandom_range(5, 60));
      display[2*SEGW +: SEGW] = 8'($urandom);
    end

    // Randomized traffic
    repeat (3000) begin
      @(negedge clock);
      if ($urandom_range(0, 15) == 0) display = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 63) == 0) bright  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 127) == 0) en     = 5'($urandom);
      if ($urandom_range(0, 127) == 0) blink  = 5'($urandom);
    end

    // Asynchronous reset in the middle of a slot
    bright = 4'd15;
    en     = 5'h1F;
    blink  = 5'h00;
    for (int i = 0; i < 64 && (n % SLOT) != 10; i++) @(negedge clock);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    run(3);
    rst = 1'b1;
    run(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
